mem_bus_bridge: RTL and testbench

- Parametrised, registered successor to the combinational RAM data-bus buffer.
- Sits between the CPU internal data/address bus and the external memory bus.
- Runs a complete read or write bus cycle from a single request: address setup, strobe with programmable wait states plus external wait extension, write-data hold, and a guaranteed bus-turnaround gap.
- Guarantees the external data bus is never driven while the memory output enable is asserted.

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/bus_tristate_drv.sv | 14 +
 rtl/mem_bus_bridge.sv | 119 +++++++++++
 tb/tb_mem_bus_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and sizing helpers for the external memory bus bridge.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TURN   = 2'd3
    } bus_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_TURN_CYCLES = 1;

    // Width of a down-counter that must hold values 0..n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/bus_tristate_drv.sv
// Tri-state pad driver for the external data bus; the only source of Z in the bridge.
module bus_tristate_drv #(
    parameter int DATA_W = 8
) (
    input  logic              drive_en,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  tri   [DATA_W-1:0] pad
);

    assign pad = drive_en ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/mem_bus_bridge.sv
// Registered CPU-to-external-memory bridge: runs a full read/write bus cycle
// (setup, strobe with wait states, data hold, turnaround) from one request.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ext_addr,
    inout  tri   [DATA_W-1:0] ext_data,
    output logic              ext_oe,
    output logic              ext_we,
    input  logic              ext_wait
);

    localparam int WCW = cnt_width(WAIT_CYCLES);
    localparam int TCW = cnt_width(TURN_CYCLES);

    bus_state_t        state, state_nx;
    logic [WCW-1:0]    wcnt;
    logic [TCW-1:0]    tcnt;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] bus_in;
    logic              drive_en;
    logic              access_end;
    logic              turn_first;
    logic              turn_last;

    // ext_wait only matters once the programmed wait states are used up.
    assign access_end = (state == ACCESS) && (wcnt == '0) && !ext_wait;
    assign turn_first = (state == TURN) && (tcnt == TCW'(TURN_CYCLES - 1));
    assign turn_last  = (state == TURN) && (tcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        ext_oe   = 1'b0;
        ext_we   = 1'b0;
        case (state)
            IDLE:   if (req) state_nx = SETUP;
            SETUP:  begin
                busy     = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                busy   = 1'b1;
                ext_oe = !we_q;
                ext_we = we_q;
                if (access_end) state_nx = TURN;
            end
            TURN:   begin
                busy = 1'b1;
                done = turn_last;
                if (turn_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write data is held from SETUP through the first TURN cycle; gating with
    // ext_oe keeps the bus contention-free even if the decode is ever changed.
    assign drive_en = we_q && !ext_oe &&
                      ((state == SETUP) || (state == ACCESS) || turn_first);

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ext_addr <= '0;
            rdata    <= '0;
            wcnt     <= '0;
            tcnt     <= '0;
        end else begin
            if ((state == IDLE) && req) begin
                we_q     <= we;
                wdata_q  <= wdata;
                ext_addr <= addr;
            end
            if (state == SETUP)
                wcnt <= WCW'(WAIT_CYCLES);
            else if ((state == ACCESS) && (wcnt != '0))
                wcnt <= wcnt - WCW'(1);
            if (access_end) begin
                tcnt <= TCW'(TURN_CYCLES - 1);
                if (!we_q) rdata <= bus_in;
            end else if ((state == TURN) && (tcnt != '0)) begin
                tcnt <= tcnt - TCW'(1);
            end
        end
    end

    bus_tristate_drv #(
        .DATA_W(DATA_W)
    ) u_drv (
        .drive_en(drive_en),
        .dout    (wdata_q),
        .din     (bus_in),
        .pad     (ext_data)
    );

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: default-timing instance plus a zero-wait-state instance.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // u0: default parameters
    logic        req0, we0, ext_wait0;
    logic [15:0] addr0;
    logic [7:0]  wdata0, rdata0, rd0;
    logic        busy0, done0, ext_oe0, ext_we0;
    logic [15:0] ext_addr0;
    tri   [7:0]  ext_data0;
    logic [7:0]  mem0 [0:65535];
    int          wr0 = 0;

    // u1: WAIT_CYCLES = 0
    logic        req1, we1, ext_wait1;
    logic [15:0] addr1;
    logic [7:0]  wdata1, rdata1;
    logic        busy1, done1, ext_oe1, ext_we1;
    logic [15:0] ext_addr1;
    tri   [7:0]  ext_data1;
    logic [7:0]  mem1 [0:65535];

    always #5 clk = ~clk;

    mem_bus_bridge u0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .busy(busy0), .done(done0), .ext_addr(ext_addr0),
        .ext_data(ext_data0), .ext_oe(ext_oe0), .ext_we(ext_we0), .ext_wait(ext_wait0)
    );

    mem_bus_bridge #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .busy(busy1), .done(done1), .ext_addr(ext_addr1),
        .ext_data(ext_data1), .ext_oe(ext_oe1), .ext_we(ext_we1), .ext_wait(ext_wait1)
    );

    // Memory models: fixed read contents at two addresses, writes captured on the strobe.
    assign rd0 = (ext_addr0 == 16'h1234) ? 8'hA5 :
                 (ext_addr0 == 16'h2000) ? 8'h5A : 8'h00;
    assign ext_data0 = ext_oe0 ? rd0 : {8{1'bz}};
    assign ext_data1 = ext_oe1 ? 8'h00 : {8{1'bz}};

    always @(posedge clk) begin
        if (ext_we0) begin
            mem0[ext_addr0] <= ext_data0;
            wr0 <= wr0 + 1;
        end
        if (ext_we1) mem1[ext_addr1] <= ext_data1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor invariants, evaluated every cycle.
    task automatic mon();
        chk("inv_oe_drv0", 32'(ext_oe0 && u0.drive_en), 32'd0);
        chk("inv_oe_we0",  32'(ext_oe0 && ext_we0),     32'd0);
        chk("inv_done0",   32'(done0 && !busy0),        32'd0);
        chk("inv_oe_drv1", 32'(ext_oe1 && u1.drive_en), 32'd0);
        chk("inv_oe_we1",  32'(ext_oe1 && ext_we1),     32'd0);
        chk("inv_done1",   32'(done1 && !busy1),        32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    logic        b_we    [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] b_addr  [3] = '{16'h0100, 16'h2000, 16'h0101};
    logic [7:0]  b_wdata [3] = '{8'hC3, 8'h00, 8'h96};
    int          wsnap;

    initial begin
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; ext_wait0 = 0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; ext_wait1 = 0;
        tick();
        tick();
        chk("rst_busy",  32'(busy0),     32'd0);
        chk("rst_done",  32'(done0),     32'd0);
        chk("rst_oe",    32'(ext_oe0),   32'd0);
        chk("rst_we",    32'(ext_we0),   32'd0);
        chk("rst_addr",  32'(ext_addr0), 32'd0);
        chk("rst_rdata", 32'(rdata0),    32'd0);
        chk("rst_drv",   32'(u0.drive_en), 32'd0);
        chk("rst_busy1", 32'(busy1),     32'd0);
        rst = 1'b0;

        // Read 0x1234 with default timing
        req0 = 1; we0 = 0; addr0 = 16'h1234;
        tick();
        req0 = 0;
        chk("rd_setup_busy", 32'(busy0),     32'd1);
        chk("rd_setup_addr", 32'(ext_addr0), 32'h1234);
        chk("rd_setup_oe",   32'(ext_oe0),   32'd0);
        chk("rd_setup_drv",  32'(u0.drive_en), 32'd0);
        tick();
        chk("rd_acc1_oe", 32'(ext_oe0), 32'd1);
        tick();
        chk("rd_acc2_oe",   32'(ext_oe0), 32'd1);
        chk("rd_acc2_done", 32'(done0),   32'd0);
        tick();
        chk("rd_turn_done",  32'(done0),   32'd1);
        chk("rd_turn_oe",    32'(ext_oe0), 32'd0);
        chk("rd_turn_rdata", 32'(rdata0),  32'hA5);
        chk("rd_turn_busy",  32'(busy0),   32'd1);
        tick();
        chk("rd_idle_busy",  32'(busy0),  32'd0);
        chk("rd_idle_done",  32'(done0),  32'd0);
        chk("rd_idle_rdata", 32'(rdata0), 32'hA5);

        // Write interrupted by reset while in ACCESS
        req0 = 1; we0 = 1; addr0 = 16'h0055; wdata0 = 8'h77;
        tick();
        req0 = 0;
        chk("mw_setup_drv",  32'(u0.drive_en), 32'd1);
        chk("mw_setup_data", 32'(ext_data0),   32'h77);
        chk("mw_setup_we",   32'(ext_we0),     32'd0);
        tick();
        chk("mw_acc_we", 32'(ext_we0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mw_rst_we",    32'(ext_we0),     32'd0);
        chk("mw_rst_drv",   32'(u0.drive_en), 32'd0);
        chk("mw_rst_busy",  32'(busy0),       32'd0);
        chk("mw_rst_done",  32'(done0),       32'd0);
        chk("mw_rst_addr",  32'(ext_addr0),   32'd0);
        chk("mw_rst_rdata", 32'(rdata0),      32'd0);
        tick();
        chk("mw_post_busy", 32'(busy0), 32'd0);
        chk("mw_post_done", 32'(done0), 32'd0);

        // Read 0x2000 stretched by ext_wait for 3 cycles; done on the 7th tick
        req0 = 1; we0 = 0; addr0 = 16'h2000;
        tick();                 // 1: SETUP
        req0 = 0;
        tick();                 // 2: ACCESS
        tick();                 // 3: ACCESS, last counted cycle
        ext_wait0 = 1;
        tick();                 // 4
        chk("wt_t4_oe",   32'(ext_oe0), 32'd1);
        chk("wt_t4_done", 32'(done0),   32'd0);
        tick();                 // 5
        tick();                 // 6
        chk("wt_t6_oe",   32'(ext_oe0), 32'd1);
        chk("wt_t6_done", 32'(done0),   32'd0);
        ext_wait0 = 0;
        tick();                 // 7: TURN
        chk("wt_t7_done",  32'(done0),   32'd1);
        chk("wt_t7_oe",    32'(ext_oe0), 32'd0);
        chk("wt_t7_rdata", 32'(rdata0),  32'h5A);
        tick();

        // Request while busy must be ignored
        wsnap = wr0;
        req0 = 1; we0 = 0; addr0 = 16'h1234;
        tick();
        we0 = 1; addr0 = 16'hBEEF; wdata0 = 8'h11;
        tick();
        chk("ig_acc_oe",   32'(ext_oe0),   32'd1);
        chk("ig_acc_we",   32'(ext_we0),   32'd0);
        chk("ig_acc_addr", 32'(ext_addr0), 32'h1234);
        req0 = 0;
        tick();
        tick();
        chk("ig_turn_done",  32'(done0),     32'd1);
        chk("ig_turn_rdata", 32'(rdata0),    32'hA5);
        chk("ig_turn_addr",  32'(ext_addr0), 32'h1234);
        tick();
        chk("ig_idle_busy", 32'(busy0), 32'd0);
        chk("ig_no_write",  32'(wr0),   32'(wsnap));

        // Back-to-back write/read/write with req held high
        for (int i = 0; i < 3; i++) begin
            we0 = b_we[i]; addr0 = b_addr[i]; wdata0 = b_wdata[i]; req0 = 1;
            tick();
            if (i == 2) req0 = 0;
            chk("b2b_busy", 32'(busy0),     32'd1);
            chk("b2b_addr", 32'(ext_addr0), 32'(b_addr[i]));
            tick();
            tick();
            tick();
            chk("b2b_done", 32'(done0), 32'd1);
            tick();
            chk("b2b_gap",  32'(busy0), 32'd0);
        end
        chk("b2b_mem0",  32'(mem0[16'h0100]), 32'hC3);
        chk("b2b_mem1",  32'(mem0[16'h0101]), 32'h96);
        chk("b2b_rdata", 32'(rdata0),         32'h5A);

        // Zero-wait-state write on u1
        req1 = 1; we1 = 1; addr1 = 16'h00FF; wdata1 = 8'h3C;
        tick();
        req1 = 0;
        chk("w0_setup_drv",  32'(u1.drive_en), 32'd1);
        chk("w0_setup_data", 32'(ext_data1),   32'h3C);
        chk("w0_setup_we",   32'(ext_we1),     32'd0);
        tick();
        chk("w0_acc_we",   32'(ext_we1),   32'd1);
        chk("w0_acc_data", 32'(ext_data1), 32'h3C);
        tick();
        chk("w0_turn_we",   32'(ext_we1),     32'd0);
        chk("w0_turn_drv",  32'(u1.drive_en), 32'd1);
        chk("w0_turn_data", 32'(ext_data1),   32'h3C);
        chk("w0_turn_done", 32'(done1),       32'd1);
        tick();
        chk("w0_idle_drv",  32'(u1.drive_en),     32'd0);
        chk("w0_idle_done", 32'(done1),           32'd0);
        chk("w0_mem",       32'(mem1[16'h00FF]),  32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
